// File: rtl/nios_dbg_pkg.sv
// Shared constants for the Nios debug command bridge.
// IR codes and default widths used by the bridge and its sync stages.
package nios_dbg_pkg;

  localparam int DATA_W_DEF      = 38;
  localparam int IR_W_DEF        = 2;
  localparam int DEPTH_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;

  localparam logic [1:0] IR_OCIMEM   = 2'd0;
  localparam logic [1:0] IR_TRACE    = 2'd1;
  localparam logic [1:0] IR_BREAK    = 2'd2;
  localparam logic [1:0] IR_TRACEMEM = 2'd3;

endpackage

// File: rtl/nios_dbg_toggle_sync.sv
// Toggle synchronizer: flop chain, reference flop and registered edge pulse.
// The enable gates only the pulse so the reference keeps tracking during warm-up.
module nios_dbg_toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tgl_i,
  input  logic en_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ref_q, ref_d;
  logic                   pulse_q, pulse_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], tgl_i};
    ref_d   = sync_q[SYNC_STAGES-1];
    pulse_d = en_i & (sync_q[SYNC_STAGES-1] ^ ref_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      ref_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      ref_q   <= ref_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/nios_debug_cmd_bridge.sv
// Bridges JTAG Update-DR/IR toggles into a clk-domain show-ahead command FIFO.
// Update-IR only raises ir_update; Update-DR queues {ir_in, sr}.
module nios_debug_cmd_bridge
  import nios_dbg_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     udr_tgl,
  input  logic                     uir_tgl,
  input  logic [IR_W-1:0]          ir_in,
  input  logic [DATA_W-1:0]        sr,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [IR_W-1:0]          cmd_ir,
  output logic [DATA_W-1:0]        cmd_data,
  output logic                     ir_update,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int WCW = $clog2(SYNC_STAGES + 2);
  localparam logic [WCW-1:0] WARM_DONE = WCW'(SYNC_STAGES + 1);

  typedef logic [IR_W+DATA_W-1:0] entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q, ovf_d;
  logic [WCW-1:0]  warm_q, warm_d;
  logic            warm_done;
  logic            push, pop, full, wr_en;

  assign warm_done = (warm_q == WARM_DONE);

  nios_dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk     (clk),
    .reset   (reset),
    .tgl_i   (udr_tgl),
    .en_i    (warm_done),
    .pulse_o (push)
  );

  nios_dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk     (clk),
    .reset   (reset),
    .tgl_i   (uir_tgl),
    .en_i    (warm_done),
    .pulse_o (ir_update)
  );

  always_comb begin
    full     = (level_q == LW'(DEPTH));
    pop      = (level_q != '0) & cmd_ready;
    // A full FIFO still accepts a push when the head leaves this cycle.
    wr_en    = push & (~full | pop);
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    ovf_d    = (ovf_q & ~overflow_clr) | (push & ~wr_en);
    warm_d   = warm_done ? warm_q : warm_q + WCW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      warm_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      warm_q   <= warm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {ir_in, sr};
  end

  assign cmd_valid = (level_q != '0);
  assign {cmd_ir, cmd_data} = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_nios_debug_cmd_bridge.sv
// Bench for nios_debug_cmd_bridge: vector table plus scoreboard queue.
// Hand sequences cover timing, full push/pop, reset and warm-up cases.
module tb_nios_debug_cmd_bridge;
  import nios_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        udr_tgl, uir_tgl;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic        ir_update;
  logic [2:0]  level;
  logic        overflow, overflow_clr;

  nios_debug_cmd_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .udr_tgl      (udr_tgl),
    .uir_tgl      (uir_tgl),
    .ir_in        (ir_in),
    .sr           (sr),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_ir       (cmd_ir),
    .cmd_data     (cmd_data),
    .ir_update    (ir_update),
    .level        (level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] data;
    logic [2:0]  exp_level;
    logic        exp_ovf;
    bit          kept;
  } vec_t;

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] data;
  } cmd_t;

  vec_t vt[5];
  cmd_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_hi = 0;
  int   n_rise = 0;
  logic prev_iru = 1'b0;

  always @(negedge clk) begin
    if (ir_update === 1'b1) n_hi++;
    if (ir_update === 1'b1 && prev_iru !== 1'b1) n_rise++;
    prev_iru = ir_update;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send_udr(input logic [1:0] ir, input logic [37:0] d,
                          input logic rdy, input logic clr);
    udr_tgl = ~udr_tgl;
    ir_in   = ir;
    sr      = d;
    repeat (3) tick();
    cmd_ready    = rdy;
    overflow_clr = clr;
    tick();
    cmd_ready    = 1'b0;
    overflow_clr = 1'b0;
    repeat (2) tick();
  endtask

  task automatic pop_check(input string nm);
    cmd_t c;
    chk({nm, "_valid"}, 64'(cmd_valid), 64'd1);
    if (sbq.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_sb: got pop want empty queue", nm);
    end else begin
      c = sbq.pop_front();
      chk({nm, "_ir"}, 64'(cmd_ir), 64'(c.ir));
      chk({nm, "_data"}, 64'(cmd_data), 64'(c.data));
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  initial begin
    cmd_t c;
    int   vcnt, h0, r0;

    vt[0] = '{IR_OCIMEM,   38'h0000000011, 3'd1, 1'b0, 1'b1};
    vt[1] = '{IR_TRACE,    38'h2AAAAAAAAA, 3'd2, 1'b0, 1'b1};
    vt[2] = '{IR_BREAK,    38'h1555555555, 3'd3, 1'b0, 1'b1};
    vt[3] = '{IR_TRACEMEM, 38'h3FFFFFFFFF, 3'd4, 1'b0, 1'b1};
    vt[4] = '{IR_BREAK,    38'h0123456789, 3'd4, 1'b1, 1'b0};

    reset = 1'b1;
    udr_tgl = 1'b0;
    uir_tgl = 1'b0;
    ir_in = '0;
    sr = '0;
    cmd_ready = 1'b0;
    overflow_clr = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_iru", 64'(ir_update), 64'd0);
    reset = 1'b0;
    repeat (6) tick();

    udr_tgl = 1'b1;
    ir_in   = IR_BREAK;
    sr      = 38'h15A5A5A5A;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("lat_edge%0d", e), 64'(cmd_valid), 64'(e == 4));
    end
    chk("single_ir", 64'(cmd_ir), 64'(IR_BREAK));
    chk("single_data", 64'(cmd_data), 64'h15A5A5A5A);
    chk("single_level", 64'(level), 64'd1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("single_pop_valid", 64'(cmd_valid), 64'd0);
    chk("single_pop_level", 64'(level), 64'd0);

    cmd_ready = 1'b1;
    repeat (3) tick();
    cmd_ready = 1'b0;
    chk("empty_ready_level", 64'(level), 64'd0);
    chk("empty_ready_valid", 64'(cmd_valid), 64'd0);

    for (int i = 0; i < 5; i++) begin
      send_udr(vt[i].ir, vt[i].data, 1'b0, 1'b0);
      if (vt[i].kept) sbq.push_back('{vt[i].ir, vt[i].data});
      chk($sformatf("vec%0d_level", i), 64'(level), 64'(vt[i].exp_level));
      chk($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vt[i].exp_ovf));
    end

    send_udr(IR_TRACE, 38'h0BADBADBAD, 1'b0, 1'b1);
    chk("clr_drop_ovf", 64'(overflow), 64'd1);
    chk("clr_drop_level", 64'(level), 64'd4);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("clr_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) pop_check($sformatf("ovf_pop%0d", i));
    chk("ovf_drain_level", 64'(level), 64'd0);

    for (int i = 0; i < 4; i++) begin
      send_udr(2'(i), 38'h1000000000 + 38'(i), 1'b0, 1'b0);
      sbq.push_back('{2'(i), 38'h1000000000 + 38'(i)});
    end
    chk("pp_full_level", 64'(level), 64'd4);
    c = sbq.pop_front();
    chk("pp_head_ir", 64'(cmd_ir), 64'(c.ir));
    chk("pp_head_data", 64'(cmd_data), 64'(c.data));
    send_udr(IR_TRACEMEM, 38'h2222222222, 1'b1, 1'b0);
    sbq.push_back('{IR_TRACEMEM, 38'h2222222222});
    chk("pp_level", 64'(level), 64'd4);
    chk("pp_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) pop_check($sformatf("pp_pop%0d", i));
    chk("pp_drain_level", 64'(level), 64'd0);

    for (int i = 0; i < 3; i++) send_udr(IR_TRACE, 38'(i + 7), 1'b0, 1'b0);
    chk("mid_level3", 64'(level), 64'd3);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(cmd_valid), 64'd0);
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    sbq.delete();
    reset = 1'b0;
    repeat (6) tick();
    chk("post_rst_idle", 64'(cmd_valid), 64'd0);
    send_udr(IR_OCIMEM, 38'h3333333333, 1'b0, 1'b0);
    sbq.push_back('{IR_OCIMEM, 38'h3333333333});
    chk("post_rst_level", 64'(level), 64'd1);
    pop_check("post_rst_pop");
    chk("post_rst_drain", 64'(level), 64'd0);

    reset = 1'b1;
    udr_tgl = 1'b1;
    uir_tgl = 1'b1;
    repeat (2) tick();
    h0 = n_hi;
    reset = 1'b0;
    vcnt = 0;
    repeat (20) begin
      tick();
      if (cmd_valid !== 1'b0) vcnt++;
    end
    chk("warm_valid_cycles", 64'(vcnt), 64'd0);
    chk("warm_iru_pulses", 64'(n_hi - h0), 64'd0);
    chk("warm_level", 64'(level), 64'd0);

    h0 = n_hi;
    r0 = n_rise;
    for (int i = 0; i < 3; i++) begin
      uir_tgl = ~uir_tgl;
      repeat (8) tick();
    end
    chk("iru_hi_cycles", 64'(n_hi - h0), 64'd3);
    chk("iru_rises", 64'(n_rise - r0), 64'd3);
    chk("iru_level", 64'(level), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/nios_debug_cmd_bridge.md
NIOS_DEBUG_CMD_BRIDGE -- requirements
Module: nios_debug_cmd_bridge

Interface
REQ-001 Parameter DATA_W, default 38, width of scan-register command payload.
REQ-002 Parameter IR_W, default 2, width of instruction register field.
REQ-003 Parameter DEPTH, default 4, command FIFO entries; power of 2, >=2.
REQ-004 Parameter SYNC_STAGES, default 2, synchronizer flops per crossing; >=2.
REQ-005 clk  in  1  sole clock; all state rising-edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 udr_tgl  in  1  JTAG-domain toggle; flips once per Update-DR.
REQ-008 uir_tgl  in  1  JTAG-domain toggle; flips once per Update-IR.
REQ-009 ir_in  in  IR_W  JTAG IR value; source holds it stable >=SYNC_STAGES+2 clk after a toggle.
REQ-010 sr  in  DATA_W  JTAG scan-register value; same stability contract as ir_in.
REQ-011 cmd_valid  out  1  FIFO head holds a command.
REQ-012 cmd_ready  in  1  consumer accepts head this cycle.
REQ-013 cmd_ir  out  IR_W  IR field of head entry.
REQ-014 cmd_data  out  DATA_W  payload of head entry.
REQ-015 ir_update  out  1  one-cycle pulse per synchronized Update-IR.
REQ-016 level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-017 overflow  out  1  sticky: a command was dropped.
REQ-018 overflow_clr  in  1  clears overflow.

Function
REQ-019 Each toggle input SHALL pass through SYNC_STAGES flops, then one reference flop; edge = last sync stage XOR reference.
REQ-020 A udr edge SHALL produce one internal push pulse capturing {ir_in, sr} in the same cycle.
REQ-021 A uir edge SHALL assert ir_update for exactly one cycle; it SHALL NOT touch the FIFO.
REQ-022 With FIFO empty, cmd_valid SHALL rise exactly SYNC_STAGES+2 clk edges after the first edge sampling a changed udr_tgl.
REQ-023 FIFO SHALL be show-ahead: cmd_ir/cmd_data reflect head whenever cmd_valid=1; value undefined-but-stable when empty.
REQ-024 Pop SHALL occur when cmd_valid & cmd_ready; cmd_ready while empty SHALL be ignored.
REQ-025 Push while full and no pop: entry dropped, overflow set next cycle, level unchanged.
REQ-026 Push and pop in same cycle SHALL both succeed, including when full; level unchanged.
REQ-027 Pointers SHALL wrap modulo DEPTH; full = level==DEPTH, empty = level==0.
REQ-028 overflow_clr and a new drop in the same cycle: overflow SHALL remain 1.
REQ-029 After reset deassertion a warm-up counter SHALL suppress edge detection for SYNC_STAGES+1 cycles while reference flops track the sync chain, so a toggle already at 1 yields no spurious command.

Reset
REQ-030 Reset SHALL clear sync chains, reference flops, warm-up counter (to start), pointers, level, overflow, ir_update, cmd_valid to 0.
REQ-031 Reset mid-operation SHALL discard all queued commands; FIFO storage need not be cleared.
REQ-032 Toggle edges occurring during reset or warm-up SHALL be lost, not queued.

Structure
REQ-033 Package nios_dbg_pkg SHALL hold IR code constants (IR_OCIMEM=0, IR_TRACE=1, IR_BREAK=2, IR_TRACEMEM=3) and default width constants.
REQ-034 Sub-module nios_dbg_toggle_sync (SYNC_STAGES chain + reference flop + edge pulse, warm-up gate input) SHALL be instantiated twice.
REQ-035 FIFO SHALL be inline in the top module; no vendor RAM primitives.

Verification
REQ-036 Single command: udr_tgl 0->1, ir_in=2, sr=38'h15A5A5A5A -> cmd_valid at edge 4 (SYNC_STAGES=2), cmd_ir=2, cmd_data=38'h15A5A5A5A; cmd_ready=1 -> cmd_valid 0, level 0.
REQ-037 Overflow: 5 toggles, cmd_ready=0, DEPTH=4 -> level=4, overflow=1, popped sequence equals first 4 payloads in order.
REQ-038 Full with simultaneous push/pop: level=4, toggle with cmd_ready=1 -> level stays 4, overflow stays 0, new entry last out.
REQ-039 Reset release with udr_tgl=1, uir_tgl=1 held -> no cmd_valid, no ir_update for 20 cycles.
REQ-040 Reset asserted with level=3 -> next cycle cmd_valid=0, level=0, overflow=0; subsequent toggle yields exactly one command.
REQ-041 uir toggle 3 times, 8 cycles apart -> exactly 3 one-cycle ir_update pulses, level unchanged.
